// File: rtl/c3lib_sync_debounce.sv
// Single-bit synchroniser followed by a counter-based glitch filter.
// Define C3LIB_SYNC_DEBOUNCE_EDGE_PULSE_EN to get registered rise/fall pulses.
module c3lib_sync_debounce #(
    parameter int   SYNC_STAGES = 2,
    parameter int   DEB_CNT     = 8,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic deb_en,
    output logic data_out,
    output logic busy,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int CW = (DEB_CNT < 2) ? 1 : $clog2(DEB_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   dout_nxt;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) sync_q <= {SYNC_STAGES{RESET_VAL}};
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end

    // Any match between sync_out and data_out restarts the stability count.
    always_comb begin
        cnt_nxt  = '0;
        dout_nxt = data_out;
        if (!deb_en) begin
            dout_nxt = sync_out;
        end else if (sync_out != data_out) begin
            if (cnt == CNT_LAST) dout_nxt = sync_out;
            else                 cnt_nxt  = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            data_out <= RESET_VAL;
        end else begin
            cnt      <= cnt_nxt;
            data_out <= dout_nxt;
        end
    end

    assign busy = (cnt != '0);

`ifdef C3LIB_SYNC_DEBOUNCE_EDGE_PULSE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            rise_pulse <= dout_nxt & ~data_out;
            fall_pulse <= ~dout_nxt & data_out;
        end
    end
`else
    assign rise_pulse = 1'b0;
    assign fall_pulse = 1'b0;
`endif

endmodule

// File: doc/c3lib_sync_debounce.md
Name: c3lib_sync_debounce

Overview:
- Single-bit synchroniser plus counter-based glitch filter.
- Takes an asynchronous or slow control level, such as a pad-side enable or a strap, and produces a clean, registered level in the clk domain.
- Its output directly feeds c3lib 2-input NAND gating and combinational control primitives, which must never see metastable or glitching inputs.
- Optional edge-pulse outputs let downstream logic react to qualified transitions.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4.
- DEB_CNT, 8, consecutive stable synchronised cycles required before the output changes; legal range 1..255.
- RESET_VAL, 1'b0, value loaded into every synchroniser flop and into data_out on reset.

Ports:
- clk  input  1  block clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  asynchronous input level.
- deb_en  input  1  synchronous; 1 = debounce active, 0 = filter bypassed.
- data_out  output  1  synchronised, debounced level.
- busy  output  1  high while a candidate transition is being counted.
- rise_pulse  output  1  one-cycle pulse when data_out goes 0->1.
- fall_pulse  output  1  one-cycle pulse when data_out goes 1->0.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high. State is undefined until the first clk edge with rst=1.
- Reset: on the first clk edge with rst=1:
  - all sync flops and data_out take RESET_VAL;
  - counter = 0;
  - busy = 0;
  - rise_pulse = fall_pulse = 0.
  - Reset applied mid-count aborts the count; there is no pending flip after reset is released.
- Synchroniser: sync_out is the last of SYNC_STAGES flops in a chain. din has no combinational path to any output.
- Filter, deb_en=1, evaluated at each edge:
  - sync_out == data_out: counter <= 0.
  - sync_out != data_out and counter < DEB_CNT-1: counter <= counter+1.
  - sync_out != data_out and counter == DEB_CNT-1: data_out <= sync_out; counter <= 0.
- Latency: din changes, and edge 1 is the first edge that samples the new value. If din stays stable, data_out changes on edge SYNC_STAGES+DEB_CNT. With defaults this is edge 10.
- Glitch rejection: any sync_out excursion shorter than DEB_CNT cycles is rejected, because the counter clears as soon as sync_out matches data_out again.
- Bypass, deb_en=0:
  - counter <= 0;
  - data_out <= sync_out on every edge, so latency is SYNC_STAGES+1 edges.
- deb_en toggled mid-count:
  - 1->0: the counter clears and the bypass rule applies on the same edge.
  - 0->1: counting starts from 0.
- busy = (counter != 0). It is registered and derived from the counter register, not from next-state.
- Counter width is clog2(DEB_CNT+1), minimum 1 bit. The counter never exceeds DEB_CNT-1 and never wraps.
- DEB_CNT=1 with deb_en=1: data_out follows sync_out one edge later, the same as bypass.

Optional Feature:
- Macro: C3LIB_SYNC_DEBOUNCE_EDGE_PULSE_EN.
- Defined:
  - rise_pulse/fall_pulse are registered and go high for exactly one cycle, coincident with the first cycle data_out shows its new value.
  - They never assert together.
  - They are not asserted by reset.
- Undefined: rise_pulse and fall_pulse are tied to 0 and no pulse flops are inferred. Ports remain present in both builds.

Test Plan:
- Reset value: RESET_VAL=0 and din=1 held through reset, then rst released. data_out=0 for the first 9 edges after release and rises on edge 10. With macro: rise_pulse high for one cycle, coincident with data_out first reading 1.
- Glitch rejection: defaults, data_out=0, din pulsed high for 5 cycles. data_out stays 0; busy asserts then deasserts; no rise_pulse.
- Exact threshold: defaults. A din high pulse yielding 7 synchronised high cycles is rejected. A pulse yielding exactly 8 cycles flips data_out to 1 on the 8th counted edge; it stays 1 after din returns low until the reverse count completes.
- Bypass: deb_en=0, din toggles every 4 cycles. data_out mirrors din delayed 3 edges; busy stays 0. With macro: pulses track each edge.
- Mid-count reset: defaults, din rises, rst asserted for 1 cycle at count 5. Afterwards counter=0, busy=0, data_out=0. With din still high, data_out rises exactly 10 edges after the first post-reset edge.
- deb_en switch mid-count: counter at 4, deb_en driven 0. Next edge: data_out=sync_out, busy=0. Re-enabling deb_en with din stable produces no further change.
